// File: rtl/vend_pkg.sv
// Shared definitions for the multi-item vending controller: one-hot state
// encoding, coin codes and the coin-to-credit decode.
package vend_pkg;

    localparam int ST_IDLE    = 0;
    localparam int ST_COLLECT = 1;
    localparam int ST_VEND    = 2;
    localparam int ST_CHANGE  = 3;

    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001 << ST_IDLE,
        S_COLLECT = 4'b0001 << ST_COLLECT,
        S_VEND    = 4'b0001 << ST_VEND,
        S_CHANGE  = 4'b0001 << ST_CHANGE
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_HALF = 2'b01;
    localparam logic [1:0] COIN_ONE  = 2'b10;
    localparam logic [1:0] COIN_FIVE = 2'b11;

    // Credit is kept in 0.5-yuan units, so a 5-yuan coin is worth 10.
    function automatic logic [3:0] coin_units(input logic [1:0] code);
        logic [3:0] units;
        case (code)
            COIN_HALF: units = 4'd1;
            COIN_ONE:  units = 4'd2;
            COIN_FIVE: units = 4'd10;
            default:   units = 4'd0;
        endcase
        return units;
    endfunction

endpackage

// File: rtl/vend_change_pulser.sv
// Change-hopper driver: after a start it emits one pulse per unit of the
// loaded count at a period of two cycles and flags the final pulse.
module vend_change_pulser
    import vend_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_load,
    output logic             o_pulse,
    output logic             o_done,
    output logic [CNT_W-1:0] o_remaining
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;
    logic             r_active;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_pulse  <= 1'b0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_cnt    <= i_load;
            r_pulse  <= (i_load != '0);
            r_active <= (i_load != '0);
        end else if (r_active) begin
            // Count down on the high half so the remaining value drops after each pulse.
            if (r_pulse) begin
                r_cnt   <= r_cnt - CNT_W'(1);
                r_pulse <= 1'b0;
                if (r_cnt == CNT_W'(1)) begin
                    r_active <= 1'b0;
                end
            end else begin
                r_pulse <= 1'b1;
            end
        end
    end

    assign o_pulse     = r_pulse;
    assign o_done      = r_pulse && (r_cnt == CNT_W'(1));
    assign o_remaining = r_cnt;

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: accumulates coin credit, vends the selected
// item against a per-item price and returns change or refunds as unit pulses.
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int                          CREDIT_W   = 8,
    parameter int                          N_ITEMS    = 4,
    parameter int                          ITEM_W     = 2,
    parameter logic [N_ITEMS*CREDIT_W-1:0] PRICE_LIST = {4{8'd3}},
    parameter int                          MAX_CREDIT = 40
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [1:0]          D_in,
    input  logic [ITEM_W-1:0]   sel,
    input  logic                buy,
    input  logic                cancel,
    output logic                D_out,
    output logic [ITEM_W-1:0]   item_out,
    output logic                D_C,
    output logic                coin_rej,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] r_change;
    logic                r_dout;
    logic [ITEM_W-1:0]   r_item;
    logic                r_rej;

    logic [CREDIT_W-1:0] w_prices [N_ITEMS];
    logic [CREDIT_W-1:0] w_price;
    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W-1:0] w_new_credit;
    logic [CREDIT_W-1:0] w_load;
    logic [CREDIT_W-1:0] w_remaining;
    logic                w_busy;
    logic                w_coin;
    logic                w_over;
    logic                w_coin_ok;
    logic                w_afford;
    logic                w_start;
    logic                w_done;
    logic                w_dc;

    for (genvar gi = 0; gi < N_ITEMS; gi++) begin : g_price
        assign w_prices[gi] = PRICE_LIST[gi*CREDIT_W +: CREDIT_W];
    end
    assign w_price = w_prices[sel];

    assign w_busy = r_state[ST_VEND] || r_state[ST_CHANGE];
    assign w_coin = (D_in != COIN_NONE);

    // One extra bit on the sum so an overflowing coin is rejected instead of wrapping.
    assign w_sum        = {1'b0, r_credit} + (CREDIT_W+1)'(coin_units(D_in));
    assign w_over       = w_sum > (CREDIT_W+1)'(MAX_CREDIT);
    assign w_coin_ok    = w_coin && !w_busy && !w_over;
    assign w_new_credit = w_coin_ok ? w_sum[CREDIT_W-1:0] : r_credit;

    // Affordability uses the credit before any same-cycle coin; that coin still lands in the change.
    assign w_afford = (r_credit >= w_price);
    assign w_start  = (r_state[ST_COLLECT] && cancel) || (r_state[ST_VEND] && (r_change != '0));
    assign w_load   = r_state[ST_COLLECT] ? w_new_credit : r_change;

    vend_change_pulser #(
        .CNT_W(CREDIT_W)
    ) u_pulser (
        .i_clk      (Clk),
        .i_rst_n    (Reset),
        .i_start    (w_start),
        .i_load     (w_load),
        .o_pulse    (w_dc),
        .o_done     (w_done),
        .o_remaining(w_remaining)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state  <= S_IDLE;
            r_credit <= '0;
            r_change <= '0;
            r_dout   <= 1'b0;
            r_item   <= '0;
            r_rej    <= 1'b0;
        end else begin
            r_dout <= 1'b0;
            r_item <= '0;
            r_rej  <= w_coin && (w_busy || w_over);
            case (r_state)
                S_IDLE: begin
                    if (w_coin_ok) begin
                        r_credit <= w_sum[CREDIT_W-1:0];
                        r_state  <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (cancel) begin
                        r_credit <= '0;
                        r_state  <= S_CHANGE;
                    end else if (buy && w_afford) begin
                        r_change <= w_new_credit - w_price;
                        r_credit <= '0;
                        r_dout   <= 1'b1;
                        r_item   <= sel;
                        r_state  <= S_VEND;
                    end else begin
                        r_credit <= w_new_credit;
                    end
                end
                S_VEND: begin
                    r_state <= (r_change != '0) ? S_CHANGE : S_IDLE;
                end
                S_CHANGE: begin
                    if (w_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // While returning change the credit port tracks the units still owed.
    assign credit   = r_state[ST_CHANGE] ? w_remaining : r_credit;
    assign D_out    = r_dout;
    assign item_out = r_item;
    assign coin_rej = r_rej;
    assign D_C      = w_dc;
    assign busy     = w_busy;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed bench for vend_ctrl_multi: a vector table for single-cycle behaviour
// plus hand-written sequences for change trains, refunds and reset abort.
module tb_vend_ctrl_multi;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [1:0] D_in;
    logic [1:0] sel;
    logic       buy;
    logic       cancel;
    logic       D_out;
    logic [1:0] item_out;
    logic       D_C;
    logic       coin_rej;
    logic [7:0] credit;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] d;
        logic [1:0] s;
        logic       b;
        logic       c;
        logic       dout;
        logic [1:0] item;
        logic       dc;
        logic       rej;
        int         cr;
        logic       bsy;
    } vec_t;

    vec_t vt[$];

    // Item 3 is priced differently so the price lookup is exercised.
    vend_ctrl_multi #(
        .CREDIT_W  (8),
        .N_ITEMS   (4),
        .ITEM_W    (2),
        .PRICE_LIST({8'd5, 8'd3, 8'd3, 8'd3}),
        .MAX_CREDIT(40)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .D_in    (D_in),
        .sel     (sel),
        .buy     (buy),
        .cancel  (cancel),
        .D_out   (D_out),
        .item_out(item_out),
        .D_C     (D_C),
        .coin_rej(coin_rej),
        .credit  (credit),
        .busy    (busy)
    );

    always #5 Clk = ~Clk;

    function automatic vec_t mk(input logic [1:0] d, input logic [1:0] s, input logic b,
                                input logic c, input logic dout, input logic [1:0] item,
                                input logic dc, input logic rej, input int cr, input logic bsy);
        vec_t v;
        v.d = d; v.s = s; v.b = b; v.c = c;
        v.dout = dout; v.item = item; v.dc = dc; v.rej = rej; v.cr = cr; v.bsy = bsy;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input logic [1:0] d, input logic [1:0] s, input logic b, input logic c);
        @(negedge Clk);
        D_in = d; sel = s; buy = b; cancel = c;
        @(posedge Clk);
        #1;
        D_in = 2'b00; sel = 2'd0; buy = 1'b0; cancel = 1'b0;
    endtask

    // Starts just after the edge that entered VEND or CHANGE; follows the
    // machine until it is idle again and checks the pulse train shape.
    task automatic run_change(input string name, input int exp_pulses, input int exp_first,
                              input int exp_dout);
        int idx = 0;
        int n = 0;
        int first = -1;
        int b2b = 0;
        int n_dout = 0;
        logic prev = 1'b0;
        while (busy && idx < 200) begin
            if (D_C) begin
                n++;
                if (first < 0) first = idx;
                if (prev) b2b++;
            end
            if (D_out) n_dout++;
            prev = D_C;
            @(posedge Clk);
            #1;
            idx++;
        end
        chk({name, " finished in budget"}, int'(idx < 200), 1);
        chk({name, " pulse count"}, n, exp_pulses);
        chk({name, " first pulse offset"}, first, exp_first);
        chk({name, " back-to-back pulses"}, b2b, 0);
        chk({name, " vend strobes"}, n_dout, exp_dout);
        chk({name, " credit after"}, int'(credit), 0);
        chk({name, " D_C after"}, int'(D_C), 0);
    endtask

    initial begin
        Reset = 1'b0; D_in = 2'b00; sel = 2'd0; buy = 1'b0; cancel = 1'b0;

        // Coins during reset must leave no trace.
        repeat (3) apply(2'b01, 2'd0, 1'b0, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        chk("reset credit", int'(credit), 0);
        chk("reset D_out", int'(D_out), 0);
        chk("reset item_out", int'(item_out), 0);
        chk("reset D_C", int'(D_C), 0);
        chk("reset coin_rej", int'(coin_rej), 0);
        chk("reset busy", int'(busy), 0);

        //          d  s  b  c  dout item dc rej cr bsy
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 3, 0));
        vt.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 2, 0));
        vt.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 2, 0));
        vt.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 3, 0));
        vt.push_back(mk(0, 1, 1, 0, 1, 1, 0, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 2, 1, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 3, 0));
        vt.push_back(mk(2, 0, 1, 0, 1, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 3, 0));
        vt.push_back(mk(0, 3, 1, 1, 0, 0, 1, 0, 3, 1));
        vt.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 2, 1));
        vt.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 2, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 2, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 3, 0));
        vt.push_back(mk(0, 3, 1, 0, 0, 0, 0, 0, 3, 0));
        vt.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 5, 0));
        vt.push_back(mk(0, 3, 1, 0, 1, 3, 0, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vt.size(); i++) begin
            apply(vt[i].d, vt[i].s, vt[i].b, vt[i].c);
            chk($sformatf("row%0d D_out", i), int'(D_out), int'(vt[i].dout));
            chk($sformatf("row%0d item_out", i), int'(item_out), int'(vt[i].item));
            chk($sformatf("row%0d D_C", i), int'(D_C), int'(vt[i].dc));
            chk($sformatf("row%0d coin_rej", i), int'(coin_rej), int'(vt[i].rej));
            chk($sformatf("row%0d credit", i), int'(credit), vt[i].cr);
            chk($sformatf("row%0d busy", i), int'(busy), int'(vt[i].bsy));
        end

        // 5-yuan coin, buy item 2 at 3 units: 7 units of change.
        apply(2'b11, 2'd0, 1'b0, 1'b0);
        chk("vend7 credit", int'(credit), 10);
        apply(2'b00, 2'd2, 1'b1, 1'b0);
        chk("vend7 D_out", int'(D_out), 1);
        chk("vend7 item_out", int'(item_out), 2);
        run_change("vend7", 7, 1, 1);

        // Build 38 units, overflow coin rejected, then a full refund.
        repeat (3) apply(2'b11, 2'd0, 1'b0, 1'b0);
        repeat (4) apply(2'b10, 2'd0, 1'b0, 1'b0);
        chk("refund38 credit", int'(credit), 38);
        apply(2'b11, 2'd0, 1'b0, 1'b0);
        chk("refund38 coin_rej", int'(coin_rej), 1);
        chk("refund38 credit kept", int'(credit), 38);
        apply(2'b00, 2'd0, 1'b0, 1'b1);
        run_change("refund38", 38, 0, 0);

        // Exactly the ceiling is accepted; reset during the refund aborts it.
        repeat (4) apply(2'b11, 2'd0, 1'b0, 1'b0);
        chk("ceiling credit", int'(credit), 40);
        chk("ceiling coin_rej", int'(coin_rej), 0);
        apply(2'b01, 2'd0, 1'b0, 1'b0);
        chk("over ceiling coin_rej", int'(coin_rej), 1);
        chk("over ceiling credit", int'(credit), 40);
        apply(2'b00, 2'd0, 1'b0, 1'b1);
        chk("abort first D_C", int'(D_C), 1);
        repeat (6) begin
            @(posedge Clk);
            #1;
        end
        chk("abort fourth D_C", int'(D_C), 1);
        chk("abort remaining", int'(credit), 37);
        Reset = 1'b0;
        #1;
        chk("abort D_C drop", int'(D_C), 0);
        chk("abort credit", int'(credit), 0);
        chk("abort busy", int'(busy), 0);
        repeat (2) @(posedge Clk);
        #1;
        chk("abort D_C held low", int'(D_C), 0);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        chk("post-abort credit", int'(credit), 0);
        chk("post-abort busy", int'(busy), 0);
        chk("post-abort D_C", int'(D_C), 0);
        apply(2'b01, 2'd0, 1'b0, 1'b0);
        chk("post-abort coin accepted", int'(credit), 1);
        apply(2'b00, 2'd0, 1'b0, 1'b1);
        run_change("post-abort refund", 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
